instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Front end of the RV32I core. Owns the PC register and issues word fetches to instruction memory over a valid/ready request channel.
//   Queues returned instruction words with their PCs in a small FIFO and presents the head entry (instr, pc, opcode/funct3/funct7 slices) to decoder_controller and imm_gen.
//   Discards the in-flight and queued stream when pc_next_logic signals a redirect (taken branch, jal, jalr).
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC of first fetch after reset; bits[1:0] must be 0
//   DEPTH     2              FIFO entries = max (queued + in-flight) fetches; power of 2, >=2
// PORTS
//   clk             in   1   clock, rising edge
//   rst             in   1   asynchronous, active-high reset
//   imem_req_valid  out  1   fetch request valid
//   imem_req_ready  in   1   imem accepts request
//   imem_req_addr   out  32  fetch address (= fetch_pc)
//   imem_rsp_valid  in   1   response valid; in order, >=1 cycle after accept, always accepted
//   imem_rsp_data   in   32  instruction word
//   redirect_valid  in   1   flush and restart fetch
//   redirect_pc     in   32  restart address; bits[1:0] ignored (forced 0)
//   instr_valid     out  1   head entry valid
//   instr_ready     in   1   consumer takes head entry
//   instr           out  32  head instruction; 32'h0000_0013 (NOP) when empty
//   instr_pc        out  32  PC of head instruction; 0 when empty
//   opcode          out  7   instr[6:0]
//   funct3          out  3   instr[14:12]
//   funct7          out  7   instr[31:25]
// BEHAVIOUR
//   - Reset (async, rst=1): fetch_pc=RESET_PC, FIFO empty, inflight=0, drop_cnt=0, state=FETCH.
//     Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, instr_valid=0, instr=NOP, instr_pc=0.
//   - State: FETCH (drop_cnt==0) / DRAIN (drop_cnt>0); DRAIN->FETCH when the last stale response is dropped.
//   - Credit: free = DEPTH - fifo_count - inflight + (instr_valid & instr_ready).
//   - imem_req_valid = !rst & (free>0) & !redirect_valid. May deassert without handshake (imem tolerates).
//   - Request fire (valid & ready): fetch_pc += 4 (mod 2^32; 0xFFFF_FFFC wraps to 0), inflight++, PC pushed to tag queue.
//   - Response fire, DRAIN: drop_cnt--, inflight--, data discarded.
//   - Response fire, FETCH: push {data, tag PC} to FIFO, inflight--.
//   - Response with inflight==0: protocol error, ignored, no state change.
//   - Latency: request accepted in cycle t, response in t+k -> instr_valid in t+k+1 (no bypass).
//   - Throughput: k=1, DEPTH>=2, instr_ready=1 sustains 1 instr/cycle.
//   - Consume: instr_valid & instr_ready pops head; instr_valid never depends combinationally on redirect_valid or instr_ready.
//   - Redirect (cycle t), effective t+1:
//     fetch_pc = {redirect_pc[31:2], 2'b00}; FIFO and tag queue flushed; no request issued in t;
//     drop_cnt = drop_cnt + inflight_next (responses still outstanding after cycle t); state = DRAIN if nonzero.
//     Response arriving in t is dropped. A consume in t completes normally.
//   - Back-to-back redirects: each re-targets fetch_pc; drop_cnt accumulates correctly.
//   - Reset mid-operation: all state cleared immediately; imem is reset by the same rst, so no stale responses after reset.
// TESTING
//   1. Reset release, RESET_PC=0, imem ready=1, k=1, instr_ready=1
//      -> addrs 0,4,8,... one per cycle; instr_valid from 2nd cycle after first accept; instr_pc tracks addr.
//   2. As 1, instr_ready=0 after reset
//      -> exactly 2 fetches (0,4), imem_req_valid=0 while FIFO full;
//         ready=1 -> pops pc 0 then 4, fetch resumes at 8 the same cycle as the first pop.
//   3. k=3, two requests in flight (0,4); redirect to 0x100
//      -> both responses dropped, next request addr 0x100, first instr_pc=0x100, DRAIN->FETCH after 2nd drop.
//   4. redirect_pc=0x103 -> next imem_req_addr=0x100; redirect coincident with response -> response discarded.
//   5. RESET_PC=0xFFFF_FFF8 -> request addrs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
//   6. Assert rst mid-stream with FIFO full
//      -> instr_valid=0, instr=0x13, imem_req_valid=0 immediately (before next clk edge); restart at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues word fetches over a valid/ready
// channel, queues returned words with their PCs and presents the head entry to decode.
// Redirects flush the queue and drop every response still outstanding at that point.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DepthW = DEPTH[CW:0];
  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic [0:0] {StFetch, StDrain} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [AW-1:0]   fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
  logic [AW-1:0]   tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
  logic [31:0]     fifo_data [DEPTH];
  logic [31:0]     fifo_pc   [DEPTH];
  logic [31:0]     tag_pc    [DEPTH];
  logic [CW:0]     free;
  logic            pop, req_fire, rsp_fire, rsp_drop, rsp_push;
  logic            unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign instr_valid    = (fifo_cnt_q != '0);
  assign pop            = instr_valid & instr_ready;
  // Stale in-flight fetches still hold a credit until their response is dropped.
  assign free           = DepthW - {1'b0, fifo_cnt_q} - {1'b0, inflight_q} + (CW + 1)'(pop);
  assign imem_req_valid = !rst && (free != '0) && !redirect_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_fire       = imem_rsp_valid & (inflight_q != '0);
  assign rsp_drop       = rsp_fire & ((state_q == StDrain) | redirect_valid);
  assign rsp_push       = rsp_fire & ~rsp_drop;

  assign instr    = instr_valid ? fifo_data[fifo_rd_q] : Nop;
  assign instr_pc = instr_valid ? fifo_pc[fifo_rd_q] : 32'h0;
  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];

  // Next-state for PC, counters and queue pointers.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    fifo_cnt_d = fifo_cnt_q;
    drop_cnt_d = drop_cnt_q;
    fifo_rd_d  = fifo_rd_q;
    fifo_wr_d  = fifo_wr_q;
    tag_rd_d   = tag_rd_q;
    tag_wr_d   = tag_wr_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_fire);
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      fifo_cnt_d = '0;
      fifo_rd_d  = '0;
      fifo_wr_d  = '0;
      tag_rd_d   = '0;
      tag_wr_d   = '0;
      // Everything still outstanding after this cycle belongs to the old stream.
      drop_cnt_d = inflight_d;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        tag_wr_d   = tag_wr_q + AW'(1);
      end
      if (rsp_drop) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
      if (rsp_push) begin
        fifo_wr_d = fifo_wr_q + AW'(1);
        tag_rd_d  = tag_rd_q + AW'(1);
      end
      if (pop) begin
        fifo_rd_d = fifo_rd_q + AW'(1);
      end
      fifo_cnt_d = fifo_cnt_q + CW'(rsp_push) - CW'(pop);
    end
  end

  // FSM next state: drain while stale responses remain.
  always_comb begin
    state_d = StFetch;
    if (drop_cnt_d != '0) begin
      state_d = StDrain;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StFetch;
      fetch_pc_q <= RESET_PC;
      fifo_cnt_q <= '0;
      inflight_q <= '0;
      drop_cnt_q <= '0;
      fifo_rd_q  <= '0;
      fifo_wr_q  <= '0;
      tag_rd_q   <= '0;
      tag_wr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      fifo_cnt_q <= fifo_cnt_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_wr_q  <= fifo_wr_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
    end
  end

  // Tag and instruction storage; validity is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      tag_pc[tag_wr_q] <= fetch_pc_q;
    end
    if (rsp_push) begin
      fifo_data[fifo_wr_q] <= imem_rsp_data;
      fifo_pc[fifo_wr_q]   <= tag_pc[tag_rd_q];
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed, table-driven bench for instr_fetch_unit with a variable-latency imem model.
module tb_instr_fetch_unit;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        ir;
    logic        rv;
    logic [31:0] rpc;
    int          k;
    logic        spur;
    logic        e_rq;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_pc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid, instr_ready = 1'b0;
  logic [31:0] instr, instr_pc;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;

  // Second instance for the PC wrap case, with a fixed one-cycle responder.
  logic        rst2 = 1'b1;
  logic        rq2_valid, rsp2_valid = 1'b0, iv2;
  logic [31:0] rq2_addr, rsp2_data = 32'h0, instr2, ipc2;
  logic [6:0]  opc2, f7_2;
  logic [2:0]  f3_2;

  logic        mdl_valid = 1'b0;
  logic [31:0] mdl_data = 32'h0;
  logic        spur = 1'b0;
  int          k = 1;
  int          cyc = 0;
  logic [31:0] q_addr[$];
  int          q_due[$];

  vec_t        vecs[$];
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  assign imem_rsp_valid = mdl_valid | spur;
  assign imem_rsp_data  = spur ? 32'hDEAD_BEEF : mdl_data;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .opcode         (opcode),
    .funct3         (funct3),
    .funct7         (funct7)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut2 (
    .clk            (clk),
    .rst            (rst2),
    .imem_req_valid (rq2_valid),
    .imem_req_ready (1'b1),
    .imem_req_addr  (rq2_addr),
    .imem_rsp_valid (rsp2_valid),
    .imem_rsp_data  (rsp2_data),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .instr_valid    (iv2),
    .instr_ready    (1'b1),
    .instr          (instr2),
    .instr_pc       (ipc2),
    .opcode         (opc2),
    .funct3         (f3_2),
    .funct7         (f7_2)
  );

  // imem model: accepted requests answered in order, k cycles after accept, data = ~addr.
  always @(posedge clk) begin
    if (rst) begin
      q_addr.delete();
      q_due.delete();
    end else begin
      if (mdl_valid) begin
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end
      if (imem_req_valid && imem_req_ready) begin
        q_addr.push_back(imem_req_addr);
        q_due.push_back(cyc + k);
      end
    end
    cyc <= cyc + 1;
  end

  // Present the head response once it is due.
  always @(negedge clk) begin
    if (q_due.size() > 0 && q_due[0] <= cyc) begin
      mdl_valid <= 1'b1;
      mdl_data  <= ~q_addr[0];
    end else begin
      mdl_valid <= 1'b0;
      mdl_data  <= 32'h0;
    end
  end

  // One-cycle responder for the wrap instance.
  always @(posedge clk) begin
    rsp2_valid <= !rst2 && rq2_valid;
    rsp2_data  <= ~rq2_addr;
  end

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic rdy, input logic ir, input logic rv,
                     input logic [31:0] rpc, input int kk, input logic sp, input logic erq,
                     input logic [31:0] ea, input logic eiv, input logic [31:0] epc);
    vec_t v;
    v.rst = r;  v.rdy = rdy; v.ir = ir; v.rv = rv; v.rpc = rpc; v.k = kk; v.spur = sp;
    v.e_rq = erq; v.e_addr = ea; v.e_iv = eiv; v.e_pc = epc;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] e_instr;
    logic [31:0] wrap_exp [3];

    //  rst rdy ir rv rpc          k  sp | rq addr          iv pc
    // Streaming, k=1, consumer always ready.
    add(1, 1, 1, 0, 32'h0,       1, 0,   0, 32'h0,        0, 32'h0);
    add(0, 1, 1, 0, 32'h0,       1, 0,   1, 32'h0,        0, 32'h0);
    add(0, 1, 1, 0, 32'h0,       1, 0,   1, 32'h4,        0, 32'h0);
    add(0, 1, 1, 0, 32'h0,       1, 0,   1, 32'h8,        1, 32'h0);
    add(0, 1, 1, 0, 32'h0,       1, 0,   1, 32'hC,        1, 32'h4);
    add(0, 1, 1, 0, 32'h0,       1, 0,   1, 32'h10,       1, 32'h8);
    // Consumer stalled: FIFO fills after two fetches, then drains and refetch resumes.
    add(1, 1, 0, 0, 32'h0,       1, 0,   0, 32'h0,        0, 32'h0);
    add(0, 1, 0, 0, 32'h0,       1, 0,   1, 32'h0,        0, 32'h0);
    add(0, 1, 0, 0, 32'h0,       1, 0,   1, 32'h4,        0, 32'h0);
    add(0, 1, 0, 0, 32'h0,       1, 0,   0, 32'h8,        1, 32'h0);
    add(0, 1, 0, 0, 32'h0,       1, 0,   0, 32'h8,        1, 32'h0);
    add(0, 1, 1, 0, 32'h0,       1, 0,   1, 32'h8,        1, 32'h0);
    add(0, 1, 1, 0, 32'h0,       1, 0,   1, 32'hC,        1, 32'h4);
    add(0, 1, 1, 0, 32'h0,       1, 0,   1, 32'h10,       1, 32'h8);
    add(0, 1, 0, 0, 32'h0,       1, 0,   0, 32'h14,       1, 32'hC);
    add(0, 1, 0, 0, 32'h0,       1, 0,   0, 32'h14,       1, 32'hC);
    // Reset with the FIFO full: outputs clear before the next edge.
    add(1, 1, 0, 0, 32'h0,       1, 0,   0, 32'h0,        0, 32'h0);
    // k=3, redirect with two fetches in flight.
    add(0, 1, 1, 0, 32'h0,       3, 0,   1, 32'h0,        0, 32'h0);
    add(0, 1, 1, 0, 32'h0,       3, 0,   1, 32'h4,        0, 32'h0);
    add(0, 1, 1, 1, 32'h100,     3, 0,   0, 32'h8,        0, 32'h0);
    add(0, 1, 1, 0, 32'h0,       3, 0,   0, 32'h100,      0, 32'h0);
    add(0, 1, 1, 0, 32'h0,       3, 0,   1, 32'h100,      0, 32'h0);
    add(0, 1, 1, 0, 32'h0,       3, 0,   1, 32'h104,      0, 32'h0);
    add(0, 1, 1, 0, 32'h0,       3, 0,   0, 32'h108,      0, 32'h0);
    add(0, 1, 1, 0, 32'h0,       3, 0,   0, 32'h108,      0, 32'h0);
    // Misaligned redirect coincident with a response and a consume.
    add(0, 1, 1, 1, 32'h103,     3, 0,   0, 32'h108,      1, 32'h100);
    add(0, 1, 1, 0, 32'h0,       3, 0,   1, 32'h100,      0, 32'h0);
    add(0, 1, 1, 0, 32'h0,       3, 0,   1, 32'h104,      0, 32'h0);
    add(0, 1, 1, 0, 32'h0,       3, 0,   0, 32'h108,      0, 32'h0);
    add(0, 1, 1, 0, 32'h0,       3, 0,   0, 32'h108,      0, 32'h0);
    add(0, 1, 1, 0, 32'h0,       3, 0,   1, 32'h108,      1, 32'h100);
    add(0, 1, 1, 0, 32'h0,       3, 0,   1, 32'h10C,      1, 32'h104);
    // Spurious response with nothing outstanding, then back-to-back redirects.
    add(1, 1, 1, 0, 32'h0,       3, 0,   0, 32'h0,        0, 32'h0);
    add(0, 0, 1, 0, 32'h0,       3, 1,   1, 32'h0,        0, 32'h0);
    add(0, 0, 1, 0, 32'h0,       3, 0,   1, 32'h0,        0, 32'h0);
    add(0, 1, 1, 0, 32'h0,       3, 0,   1, 32'h0,        0, 32'h0);
    add(0, 1, 1, 0, 32'h0,       3, 0,   1, 32'h4,        0, 32'h0);
    add(0, 1, 1, 1, 32'h200,     3, 0,   0, 32'h8,        0, 32'h0);
    add(0, 1, 1, 1, 32'h300,     3, 0,   0, 32'h200,      0, 32'h0);
    add(0, 1, 1, 0, 32'h0,       3, 0,   1, 32'h300,      0, 32'h0);
    add(0, 1, 1, 0, 32'h0,       3, 0,   1, 32'h304,      0, 32'h0);
    add(0, 1, 1, 0, 32'h0,       3, 0,   0, 32'h308,      0, 32'h0);
    add(0, 1, 1, 0, 32'h0,       3, 0,   0, 32'h308,      0, 32'h0);
    add(0, 1, 1, 0, 32'h0,       3, 0,   1, 32'h308,      1, 32'h300);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst            = vecs[i].rst;
      imem_req_ready = vecs[i].rdy;
      instr_ready    = vecs[i].ir;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      k              = vecs[i].k;
      spur           = vecs[i].spur;
      #1;
      e_instr = vecs[i].e_iv ? ~vecs[i].e_pc : 32'h0000_0013;
      chk("req_valid", i, 32'(imem_req_valid), 32'(vecs[i].e_rq));
      chk("req_addr", i, imem_req_addr, vecs[i].e_addr);
      chk("instr_valid", i, 32'(instr_valid), 32'(vecs[i].e_iv));
      chk("instr_pc", i, instr_pc, vecs[i].e_pc);
      chk("instr", i, instr, e_instr);
      chk("fields", i, {15'h0, funct7, funct3, opcode},
          {15'h0, e_instr[31:25], e_instr[14:12], e_instr[6:0]});
    end

    @(negedge clk);
    redirect_valid = 1'b0;
    spur           = 1'b0;

    // PC wrap from 0xFFFF_FFF8 through zero.
    wrap_exp[0] = 32'hFFFF_FFF8;
    wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000;
    rst2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wrap_req_valid", i, 32'(rq2_valid), 32'h1);
      chk("wrap_addr", i, rq2_addr, wrap_exp[i]);
      if (i == 2) begin
        chk("wrap_instr_valid", i, 32'(iv2), 32'h1);
        chk("wrap_instr_pc", i, ipc2, 32'hFFFF_FFF8);
        chk("wrap_instr", i, instr2, 32'h0000_0007);
      end
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
